cdc_fifo_write_arbiter: RTL and testbench



---
 rtl/cdc_fifo_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 31 +++
 rtl/cdc_fifo_write_arbiter.sv | 113 +++++++++++
 tb/tb_cdc_fifo_write_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared types and constants for the CDC FIFO and its write/read-side schedulers.
// Pure declarations; no logic, no latency.
package cdc_fifo_pkg;

   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      IDLE  = 2'd1,
      BURST = 2'd2
   } wr_state_t;

   localparam int CDC_FIFO_DATA_WIDTH    = 4;
   localparam int CDC_FIFO_ADDRESS_WIDTH = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first valid index after 'last', wrapping modulo NUM_REQ.
// Purely combinational, zero latency; applies no backpressure of its own.
module rr_priority_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         valid,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic                       found,
   output logic [$clog2(NUM_REQ)-1:0] index
);

   localparam int IW = $clog2(NUM_REQ);

   // base < NUM_REQ and off <= NUM_REQ, so one subtraction wraps correctly
   function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IW'(s);
   endfunction

   // Scan from the farthest offset inward so the nearest valid index wins.
   always_comb begin
      found = |valid;
      index = last;
      for (int off = NUM_REQ; off >= 1; off--) begin
         if (valid[wrap(last, off)]) index = wrap(last, off);
      end
   end

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin burst arbiter driving the CDC FIFO write port; sequences write-side flush.
// One idle arbitration cycle per grant, then combinational push while the owner is valid and FIFO not full.
module cdc_fifo_write_arbiter
   import cdc_fifo_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = CDC_FIFO_DATA_WIDTH,
   parameter int MAX_BURST    = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush_req,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic [DATA_WIDTH-1:0]         fifo_write_data,
   output logic                          fifo_write_increment,
   output logic                          fifo_write_reset,
   output logic [$clog2(NUM_REQ)-1:0]    grant_owner,
   output logic                          busy
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
   localparam logic [3:0]    BEAT_LAST  = 4'(MAX_BURST - 1);
   localparam logic [OW-1:0] LAST_REQ   = OW'(NUM_REQ - 1);

   wr_state_t     state_q, state_d;
   logic [FW-1:0] flush_cnt_q, flush_cnt_d;
   logic [3:0]    beat_cnt_q, beat_cnt_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] last_owner_q, last_owner_d;
   logic          pick_found;
   logic [OW-1:0] pick_index;
   logic          push;

   rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .valid (req_valid),
      .last  (last_owner_q),
      .found (pick_found),
      .index (pick_index)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FLUSH;
         flush_cnt_q  <= '0;
         beat_cnt_q   <= '0;
         owner_q      <= '0;
         last_owner_q <= LAST_REQ;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      push         = 1'b0;
      // A flush request wins in every state and restarts the flush count.
      if (flush_req) begin
         state_d     = FLUSH;
         flush_cnt_d = '0;
      end else begin
         unique case (state_q)
            FLUSH: begin
               flush_cnt_d = flush_cnt_q + FW'(1);
               if (flush_cnt_q == FLUSH_LAST) state_d = IDLE;
            end
            IDLE: begin
               if (pick_found) begin
                  owner_d      = pick_index;
                  last_owner_d = pick_index;
                  beat_cnt_d   = '0;
                  state_d      = BURST;
               end
            end
            BURST: begin
               if (!req_valid[owner_q]) begin
                  state_d = IDLE;
               end else if (!fifo_full) begin
                  push       = 1'b1;
                  beat_cnt_d = beat_cnt_q + 4'd1;
                  if (beat_cnt_q == BEAT_LAST) state_d = IDLE;
               end
            end
            default: state_d = FLUSH;
         endcase
      end
   end

   always_comb begin
      req_ready          = '0;
      req_ready[owner_q] = push;
   end

   assign fifo_write_data      = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
   assign fifo_write_increment = push;
   assign fifo_write_reset     = (state_q == FLUSH);
   assign grant_owner          = owner_q;
   assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench for the FIFO write arbiter: flush sequencing, round-robin bursts, full stall, drop, abort, async reset.
module tb_cdc_fifo_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush_req;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic [3:0]  fifo_write_data;
   logic        fifo_write_increment;
   logic        fifo_write_reset;
   logic [1:0]  grant_owner;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int seq[4];
   int pushes;

   always #5 clk = ~clk;

   cdc_fifo_write_arbiter #(
      .NUM_REQ      (4),
      .DATA_WIDTH   (4),
      .MAX_BURST    (4),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .flush_req            (flush_req),
      .req_valid            (req_valid),
      .req_data             (req_data),
      .req_ready            (req_ready),
      .fifo_full            (fifo_full),
      .fifo_write_data      (fifo_write_data),
      .fifo_write_increment (fifo_write_increment),
      .fifo_write_reset     (fifo_write_reset),
      .grant_owner          (grant_owner),
      .busy                 (busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Requester i presents i*4 + (beats it has had accepted so far).
   task automatic drive_data();
      for (int i = 0; i < 4; i++) req_data[i*4 +: 4] = 4'(i*4 + seq[i]);
   endtask

   task automatic run(input string tag, input bit exp_inc, input int exp_own,
                      input int exp_dat, input bit exp_rst, input bit exp_busy);
      drive_data();
      #1;
      check({tag, "_inc"},  fifo_write_increment, exp_inc);
      check({tag, "_rdy"},  req_ready, exp_inc ? (32'd1 << exp_own) : 32'd0);
      check({tag, "_own"},  grant_owner, exp_own);
      check({tag, "_rst"},  fifo_write_reset, exp_rst);
      check({tag, "_busy"}, busy, exp_busy);
      if (exp_inc) check({tag, "_dat"}, fifo_write_data, exp_dat);
      if (fifo_write_increment) pushes++;
      for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) seq[i]++;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected end by 100000");
      $fatal(1, "watchdog");
   end

   int own_rr[25]  = '{0,0,0,0,0, 0,1,1,1,1, 1,2,2,2,2, 2,3,3,3,3, 3,0,0,0,0};
   int dat_rr[25]  = '{0,0,1,2,3, 0,4,5,6,7, 0,8,9,10,11, 0,12,13,14,15, 0,4,5,6,7};
   bit full_st[8]  = '{0,0,0,1,1,1,0,0};
   bit inc_st[8]   = '{0,1,1,0,0,0,1,1};
   int own_st[8]   = '{0,1,1,1,1,1,1,1};
   int dat_st[8]   = '{0,8,9,0,0,0,10,11};
   bit busy_st[8]  = '{0,1,1,1,1,1,1,1};

   initial begin
      for (int i = 0; i < 4; i++) seq[i] = 0;
      rst_n     = 1'b0;
      flush_req = 1'b0;
      req_valid = 4'b0000;
      req_data  = 16'h0;
      fifo_full = 1'b0;
      pushes    = 0;

      // Reset values, then the two-cycle flush after release.
      repeat (2) @(negedge clk);
      #1;
      check("rst_reset", fifo_write_reset, 1);
      check("rst_inc",   fifo_write_increment, 0);
      check("rst_rdy",   req_ready, 0);
      check("rst_own",   grant_owner, 0);
      check("rst_busy",  busy, 1);
      rst_n = 1'b1;
      #1;
      check("flush1_reset", fifo_write_reset, 1);
      check("flush1_inc",   fifo_write_increment, 0);
      @(negedge clk); #1;
      check("flush2_reset", fifo_write_reset, 1);
      check("flush2_busy",  busy, 1);
      check("flush2_inc",   fifo_write_increment, 0);
      @(negedge clk);

      // All four requesters continuously valid.
      req_valid = 4'b1111;
      for (int c = 0; c < 25; c++)
         run($sformatf("rr%0d", c), (c % 5) != 0, own_rr[c], dat_rr[c], 1'b0, (c % 5) != 0);

      // Requester 1 alone; FIFO full for three cycles after its second beat.
      req_valid = 4'b0010;
      pushes = 0;
      for (int c = 0; c < 8; c++) begin
         fifo_full = full_st[c];
         run($sformatf("stall%0d", c), inc_st[c], own_st[c], dat_st[c], 1'b0, busy_st[c]);
      end
      fifo_full = 1'b0;
      check("stall_total", pushes, 4);

      // Requester 2 drops valid after one beat, requester 3 takes over.
      req_valid = 4'b0100;
      run("drop0", 0, 1, 0, 0, 0);
      run("drop1", 1, 2, 12, 0, 1);
      req_valid = 4'b1000;
      run("drop2", 0, 2, 0, 0, 1);
      run("drop3", 0, 2, 0, 0, 0);
      run("drop4", 1, 3, 0, 0, 1);

      // Flush pulse on beat 2 of requester 3's burst; next grant must go to 0.
      flush_req = 1'b1;
      run("abort5", 0, 3, 0, 0, 1);
      flush_req = 1'b0;
      req_valid = 4'b1001;
      run("abort6", 0, 3, 0, 1, 1);
      run("abort7", 0, 3, 0, 1, 1);
      run("abort8", 0, 3, 0, 0, 0);
      run("abort9", 1, 0, 8, 0, 1);

      // Move the grant to requester 1, then reset asynchronously mid-burst.
      req_valid = 4'b0010;
      run("pre10", 0, 0, 0, 0, 1);
      run("pre11", 0, 0, 0, 0, 0);
      run("pre12", 1, 1, 12, 0, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_inc",   fifo_write_increment, 0);
      check("arst_reset", fifo_write_reset, 1);
      check("arst_rdy",   req_ready, 0);
      check("arst_own",   grant_owner, 0);
      check("arst_busy",  busy, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
